// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a held grant.
// A grant lasts until the owner asserts done or drops its request. After every
// release there is one idle cycle. The search pointer then restarts just past the
// previous owner.
// Optional feature: define ARB_TIMEOUT_EN to revoke any grant after TIMEOUT cycles
// and pulse timeout_err.
module rr_grant_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned IDW = $clog2(N);

    // Reject out-of-range configurations at elaboration time.
    if (N < 2 || N > 16) begin : g_bad_n
        $error("rr_grant_arbiter: N must be in 2..16");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("rr_grant_arbiter: TIMEOUT must be >= 2");
    end

    typedef enum logic {StIdle, StOwn} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic [N-1:0]   req_rot;
    logic [IDW:0]   pick_sum;
    logic           pick_valid;
    logic [IDW-1:0] pick_id;
    logic           owner_req;
    logic           timeout_hit;
    logic           rel;
    logic           grant_now;

    // Requests rotated so that bit 0 corresponds to the requester at ptr.
    assign req_rot   = N'({req, req} >> ptr_q);
    assign owner_req = |(req & gnt_q);
    assign rel       = (state_q == StOwn) && (done || !owner_req || timeout_hit);
    assign grant_now = (state_q == StIdle) && pick_valid;

    // Find the first request at or after ptr, wrapping around.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        pick_sum   = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (!pick_valid && req_rot[i]) begin
                pick_valid = 1'b1;
                pick_sum   = {1'b0, ptr_q} + (IDW + 1)'(i);
                if (pick_sum >= (IDW + 1)'(N)) begin
                    pick_id = IDW'(pick_sum - (IDW + 1)'(N));
                end else begin
                    pick_id = pick_sum[IDW-1:0];
                end
            end
        end
    end

    // Next-state logic for the grant FSM.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (grant_now) begin
                    state_d  = StOwn;
                    gnt_d    = N'(1) << pick_id;
                    gnt_id_d = pick_id;
                end
            end
            StOwn: begin
                if (rel) begin
                    state_d  = StIdle;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    ptr_d    = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + IDW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM, grant and pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            terr_q, terr_d;

    assign timeout_hit = (state_q == StOwn) && (cnt_q == CntW'(TIMEOUT - 1));

    // Hold counter: cleared when a grant is issued, counts while owned.
    // A release caused by done or a dropped request is not a timeout error.
    always_comb begin
        cnt_d  = cnt_q;
        terr_d = rel && timeout_hit && !done && owner_req;
        if (grant_now) begin
            cnt_d = '0;
        end else if ((state_q == StOwn) && !rel) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Hold counter and error-pulse registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = (state_q == StOwn);

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter (N=4, TIMEOUT=16).
// Stimulus is applied on the falling edge. A reference model is stepped at the
// same time and pushes the expected outputs into a queue. A monitor pops one entry
// after each rising edge and compares it with the DUT.
module tb_rr_grant_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;
    localparam int IDW     = 2;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rstn;
    logic [N-1:0]   req;
    logic           done;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout_err;

    always #5 clk = ~clk;

    rr_grant_arbiter #(
        .N       (N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .gnt_id      (gnt_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int tests = 0;
    int fails = 0;

    // Expected {gnt, gnt_id, busy, timeout_err}.
    logic [7:0] exp_q[$];

    // Reference model: current owner (-1 = none), search start, cycles held so far.
    int owner = -1;
    int ptr   = 0;
    int held  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] expect_vec(input int own, input bit terr);
        logic [3:0] g;
        logic [1:0] id;
        g  = (own >= 0) ? 4'(1 << own) : 4'b0;
        id = (own >= 0) ? 2'(own) : 2'b0;
        return {g, id, own >= 0, terr};
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic d);
        bit terr;
        bit hit;
        terr = 1'b0;
        if (owner < 0) begin
            for (int j = 0; j < N; j++) begin
                if (owner < 0 && r[(ptr + j) % N]) begin
                    owner = (ptr + j) % N;
                    held  = 1;
                end
            end
        end else begin
            hit = TO_EN && (held == TIMEOUT);
            if (d || !r[owner] || hit) begin
                terr  = hit && !d && r[owner];
                ptr   = (owner + 1) % N;
                owner = -1;
            end else begin
                held++;
            end
        end
        exp_q.push_back(expect_vec(owner, terr));
    endtask

    task automatic step(input logic [N-1:0] r, input logic d);
        @(negedge clk);
        req  = r;
        done = d;
        model_step(r, d);
    endtask

    // Wait until just after the rising edge that consumes the last step.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        req  = '0;
        done = 1'b0;
        #1;
        chk("async reset gnt", 32'(gnt), 32'h0);
        chk("async reset busy/id/err", 32'({gnt_id, busy, timeout_err}), 32'h0);
        owner = -1;
        ptr   = 0;
        held  = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Scoreboard monitor.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rstn === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("scoreboard {gnt,id,busy,err}", 32'({gnt, gnt_id, busy, timeout_err}),
                    32'(e));
            end
        end
    end

    initial begin
        logic [N-1:0] cur;
        rstn = 1'b0;
        req  = '0;
        done = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset gnt", 32'(gnt), 32'h0);
        chk("reset busy/id/err", 32'({gnt_id, busy, timeout_err}), 32'h0);
        rstn = 1'b1;

        // 1: no requests, done pulses are ignored.
        for (int i = 0; i < 10; i++) step(4'b0000, 1'(i % 2));
        settle();
        chk("idle busy", 32'(busy), 32'h0);

        // 2: 1010 -> id 1, held until done, one idle cycle, then id 3.
        step(4'b1010, 1'b0);
        settle();
        chk("t2 first grant", 32'(gnt), 32'h2);
        repeat (3) step(4'b1010, 1'b0);
        step(4'b1010, 1'b1);
        settle();
        chk("t2 idle gap", 32'(gnt), 32'h0);
        step(4'b1010, 1'b0);
        settle();
        chk("t2 second grant", 32'(gnt), 32'h8);

        // 3: all requesting, done two cycles after each grant -> 0,1,2,3,0.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 1'b0);
            settle();
            chk("t3 rotation id", 32'(gnt_id), 32'(k % N));
            step(4'b1111, 1'b0);
            step(4'b1111, 1'b1);
        end

        // 4: id 2 drops its request; next grant goes to id 3.
        do_reset();
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b1000, 1'b0);
        settle();
        chk("t4 drop release", 32'(gnt), 32'h0);
        step(4'b1000, 1'b0);
        settle();
        chk("t4 next grant", 32'(gnt_id), 32'h3);

        // 5: reset mid-grant, then search from ptr 0 lands on id 2.
        step(4'b0100, 1'b0);
        do_reset();
        step(4'b0100, 1'b0);
        settle();
        chk("t5 post-reset grant", 32'(gnt_id), 32'h2);

        // 6: requester 0 never finishes.
        do_reset();
        step(4'b0001, 1'b0);
        for (int i = 1; i < 16; i++) step(4'b0001, 1'b0);
        settle();
        chk("t6 held 16 cycles", 32'(gnt), 32'h1);
        step(4'b0001, 1'b0);
        settle();
        if (TO_EN) begin
            chk("t6 revoked", 32'({gnt, timeout_err}), 32'h01);
        end else begin
            chk("t6 still held", 32'({gnt, timeout_err}), 32'h02);
        end
        for (int i = 17; i < 100; i++) step(4'b0001, 1'b0);
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b0);

        // Randomised traffic: slowly changing requests, occasional done.
        cur = 4'($urandom_range(0, 15));
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) cur = 4'($urandom_range(0, 15));
            step(cur, ($urandom_range(0, 4) == 0));
        end

        repeat (2) @(negedge clk);
        chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
